// File: rtl/param_fifo_if.sv
// Producer/consumer side of the FIFO: write/read handshakes, error clear,
// head data, status flags and occupancy.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             wr;
  logic             rd;
  logic             clr_err;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, wr, rd, clr_err,
    input  out, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  in, wr, rd, clr_err,
    output out, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost-full
// threshold and sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic        clk,
  input  logic        rst,
  param_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_afull;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_afull  = (r_count >= CW'(AFULL_TH));
  assign w_rd_acc = bus.rd & ~w_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign w_wr_acc = bus.wr & (~w_full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.in;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // A new error event wins over a simultaneous clear.
      if (bus.wr & w_full & ~bus.rd) r_overflow <= 1'b1;
      else if (bus.clr_err)          r_overflow <= 1'b0;

      if (bus.rd & w_empty)          r_underflow <= 1'b1;
      else if (bus.clr_err)          r_underflow <= 1'b0;
    end
  end

  assign bus.out         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = w_afull;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_param_fifo.sv
// Directed and randomized bench for param_fifo against a queue-based model.
module tb_param_fifo;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 12;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  bit               m_udf;

  param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_out;
    int               n;
    n       = q.size();
    exp_out = (n != 0) ? q[0] : '0;
    check({tag, "_out"},   32'(bus.out),         32'(exp_out));
    check({tag, "_count"}, 32'(bus.count),       32'(n));
    check({tag, "_full"},  32'(bus.full),        32'(n == DEPTH));
    check({tag, "_empty"}, 32'(bus.empty),       32'(n == 0));
    check({tag, "_afull"}, 32'(bus.almost_full), 32'(n >= AFULL_TH));
    check({tag, "_ovf"},   32'(bus.overflow),    32'(m_ovf));
    check({tag, "_udf"},   32'(bus.underflow),   32'(m_udf));
  endtask

  // Drive one cycle of inputs, update the model at the edge, check #1 after it.
  task automatic cycle(input string tag, input bit w, input bit r,
                       input logic [WIDTH-1:0] d, input bit c);
    bit m_empty, m_full, rd_acc, wr_acc;
    bus.wr      = w;
    bus.rd      = r;
    bus.in      = d;
    bus.clr_err = c;
    @(posedge clk);
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    rd_acc  = r && !m_empty;
    wr_acc  = w && (!m_full || rd_acc);
    if (w && m_full && !r) m_ovf = 1'b1;
    else if (c)            m_ovf = 1'b0;
    if (r && m_empty)      m_udf = 1'b1;
    else if (c)            m_udf = 1'b0;
    if (rd_acc) void'(q.pop_front());
    if (wr_acc) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int bias;
    checks = 0;
    errors = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    rst         = 1'b0;
    bus.in      = '0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;

    // Reset state
    #12;
    check_all("reset");
    rst = 1'b1;
    #4;

    // Test 1: three writes then three reads
    cycle("t1_w", 1, 0, 8'h11, 0);
    check("t1_head", 32'(bus.out), 32'h11);
    cycle("t1_w", 1, 0, 8'h22, 0);
    cycle("t1_w", 1, 0, 8'h33, 0);
    check("t1_cnt3", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) cycle("t1_r", 0, 1, '0, 0);
    check("t1_empty_out", 32'(bus.out), 32'h0);

    // Test 2: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) cycle("t2_fill", 1, 0, 8'(i), 0);
    check("t2_full", 32'(bus.full), 32'd1);
    cycle("t2_ovf", 1, 0, 8'hFF, 0);
    check("t2_ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_data", 32'(bus.out), 32'(i));
      cycle("t2_drain", 0, 1, '0, 0);
    end
    cycle("t2_clr", 0, 0, '0, 1);

    // Test 3: underflow and clear
    cycle("t3_udf", 0, 1, '0, 0);
    check("t3_udf_flag", 32'(bus.underflow), 32'd1);
    cycle("t3_clr", 0, 0, '0, 1);

    // Empty with wr and rd: write accepted, underflow set, clear loses to the event
    cycle("t3_wr_rd_empty", 1, 1, 8'hA5, 1);
    cycle("t3_pop", 0, 1, '0, 1);

    // Test 5: asynchronous reset with count=5
    for (int i = 0; i < 5; i++) cycle("t5_fill", 1, 0, 8'($urandom), 0);
    check("t5_cnt5", 32'(bus.count), 32'd5);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all("t5_async");
    #2;
    rst = 1'b1;
    cycle("t5_after", 1, 0, 8'h5C, 0);
    check("t5_first_word", 32'(bus.out), 32'h5C);

    // Test 4: full with simultaneous wr/rd across pointer wrap
    for (int i = 0; i < DEPTH - 1; i++) cycle("t4_fill", 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 20; i++) cycle("t4_wrrd", 1, 1, 8'(8'h80 + i), 0);
    check("t4_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle("t4_drain", 0, 1, '0, 0);

    // Randomized traffic with fill-biased and drain-biased phases
    for (int p = 0; p < 6; p++) begin
      bias = (p % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 80; i++) begin
        cycle("rand",
              $urandom_range(0, 99) < bias,
              $urandom_range(0, 99) >= bias,
              8'($urandom),
              $urandom_range(0, 15) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
